// File: rtl/mem_rmw_ctrl.sv
// Word-only DM access controller: splits byte/half/word loads and stores into aligned DM
// accesses, using read-modify-write for sub-word stores.
`timescale 1ns/1ps
module mem_rmw_ctrl #(
  parameter int unsigned DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic [31:0] dm_rdata_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q;
  logic        ready_q, resp_valid_q, resp_err_q, dm_we_q;
  logic [31:0] resp_rdata_q, dm_addr_q, dm_wdata_q;
  logic        we_q, signed_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic [4:0]  shamt;
  logic [31:0] lane_data, load_data, lane_mask, merge_data;

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = |req_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr_i[31:2]} >= DM_WORDS) begin
      req_err = 1'b1;
    end
  end

  // Lane shift works for halves too because accepted halves always have addr[0] == 0.
  always_comb begin
    shamt     = {lane_q, 3'b000};
    lane_data = dm_rdata_i >> shamt;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: load_data = dm_rdata_i;
    endcase
    lane_mask  = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
    merge_data = (dm_rdata_i & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      dm_we_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            ready_q  <= 1'b0;
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            lane_q   <= req_addr_i[1:0];
            wdata_q  <= req_wdata_i;
            if (req_err) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              dm_addr_q <= {req_addr_i[31:2], 2'b00};
              if (req_we_i && req_size_i == 2'b10) begin
                dm_wdata_q <= req_wdata_i;
                dm_we_q    <= 1'b1;
                state_q    <= StWrite;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        StRead: begin
          if (!we_q) begin
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            dm_wdata_q <= merge_data;
            dm_we_q    <= 1'b1;
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign dm_we_o      = dm_we_q;
  assign dm_addr_o    = dm_addr_q;
  assign dm_wdata_o   = dm_wdata_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: directed vector table, reset-abort and back-to-back sequences, then
// random traffic checked against a byte-array reference model of DM.
`timescale 1ns/1ps
module tb_mem_rmw_ctrl;
  localparam int unsigned DmWords = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_rmw_ctrl #(.DM_WORDS(DmWords)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .dm_we_o      (dm_we),
    .dm_addr_o    (dm_addr),
    .dm_wdata_o   (dm_wdata),
    .dm_rdata_i   (dm_rdata)
  );

  // Word-only DM fed by the DUT
  logic [31:0] dm_mem [DmWords];
  logic        mem_clear;
  logic        dm_in_range;
  logic [11:0] dm_idx;
  assign dm_in_range = dm_addr[31:2] < 30'(DmWords);
  assign dm_idx      = dm_addr[13:2];
  assign dm_rdata    = dm_in_range ? dm_mem[dm_idx] : 32'h0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DmWords; i++) dm_mem[i] <= '0;
    end else if (dm_we && dm_in_range) begin
      dm_mem[dm_idx] <= dm_wdata;
    end
  end

  // Reference model: DM as words, accessed as little-endian byte groups
  logic [31:0] ref_mem [DmWords];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wes;
  } vec_t;

  task automatic ref_access(inout vec_t v);
    logic [31:0] widx;
    logic [7:0]  b[4];
    int          off, nbytes, idx;
    logic [31:0] value;
    widx = v.addr >> 2;
    off  = int'(v.addr % 4);
    v.exp_err = (v.size == 2'd3) || (v.size == 2'd1 && v.addr % 2 != 0) ||
                (v.size == 2'd2 && off != 0) || (widx >= DmWords);
    if (v.exp_err) begin
      v.exp_rdata = 0; v.exp_lat = 1; v.exp_wes = 0;
      return;
    end
    idx = int'(widx);
    for (int k = 0; k < 4; k++) b[k] = ref_mem[idx][8*k +: 8];
    nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    if (!v.we) begin
      value = 0;
      for (int k = 0; k < nbytes; k++) value = value | (32'(b[off+k]) << (8*k));
      if (v.sgn && nbytes < 4 && b[off+nbytes-1][7]) value = value | (32'hFFFF_FFFF << (8*nbytes));
      v.exp_rdata = value; v.exp_lat = 2; v.exp_wes = 0;
    end else begin
      for (int k = 0; k < nbytes; k++) b[off+k] = v.wdata[8*k +: 8];
      ref_mem[idx] = {b[3], b[2], b[1], b[0]};
      v.exp_rdata = 0; v.exp_lat = (nbytes == 4) ? 2 : 3; v.exp_wes = 1;
    end
  endtask

  task automatic check(input string name, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
    end
  endtask

  // Issue one request from IDLE; returns latency and dm_we cycles seen before resp_valid.
  task automatic apply(input string name, input vec_t v);
    int   lat, wes;
    logic [31:0] widx;
    @(negedge clk);
    check(name, "req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wes = 0;
    while (!resp_valid && lat < 10) begin
      if (dm_we) wes++;
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL %s timeout: no resp_valid within %0d cycles", name, lat);
      return;
    end
    check(name, "latency", 32'(lat), 32'(v.exp_lat));
    check(name, "dm_we cycles", 32'(wes), 32'(v.exp_wes));
    check(name, "resp_err", 32'(resp_err), 32'(v.exp_err));
    check(name, "resp_rdata", resp_rdata, v.exp_rdata);
    widx = v.addr >> 2;
    if (widx < DmWords) check(name, "dm word", dm_mem[widx[11:0]], ref_mem[widx[11:0]]);
    @(posedge clk); #1;
    check(name, "resp_valid pulse", 32'(resp_valid), 32'd0);
    check(name, "ready after", 32'(req_ready), 32'd1);
  endtask

  vec_t vecs[18];
  vec_t v;
  int   seen_we, seen_rv, rv_count;

  initial begin
    reset = 1'b1; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DmWords; i++) ref_mem[i] = '0;

    //         we    size   sgn   addr          wdata          err   rdata          lat wes
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h12345678, 1'b0, 32'h0,        2, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'h12345678, 2, 0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'h000000AB, 1'b0, 32'h0,        3, 1};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'h1234AB78, 2, 0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        1'b0, 32'hFFFFFFAB, 2, 0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        1'b0, 32'h000000AB, 2, 0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h12,   32'h00008001, 1'b0, 32'h0,        3, 1};
    vecs[7]  = '{1'b0, 2'd2, 1'b1, 32'h10,   32'h0,        1'b0, 32'h8001AB78, 2, 0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        1'b0, 32'hFFFF8001, 2, 0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        1'b0, 32'h00008001, 2, 0};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        1'b0, 32'h00000080, 2, 0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h13,   32'h0,        1'b1, 32'h0,        1, 0};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h11,   32'h0000FFFF, 1'b1, 32'h0,        1, 0};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        1'b1, 32'h0,        1, 0};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,        1'b1, 32'h0,        1, 0};
    vecs[15] = '{1'b1, 2'd2, 1'b0, 32'h2FFC, 32'hCAFEF00D, 1'b0, 32'h0,        2, 1};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0,        1'b0, 32'hCAFEF00D, 2, 0};
    vecs[17] = '{1'b1, 2'd3, 1'b0, 32'h10,   32'hFFFFFFFF, 1'b1, 32'h0,        1, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_clear = 1'b0;
    check("reset", "req_ready", 32'(req_ready), 32'd1);
    check("reset", "resp_valid", 32'(resp_valid), 32'd0);
    check("reset", "resp_rdata", resp_rdata, 32'd0);
    check("reset", "resp_err", 32'(resp_err), 32'd0);
    check("reset", "dm_we", 32'(dm_we), 32'd0);
    check("reset", "dm_addr", dm_addr, 32'd0);
    check("reset", "dm_wdata", dm_wdata, 32'd0);

    for (int i = 0; i < 18; i++) begin
      v = vecs[i];
      ref_access(v);  // keeps the model's DM in step; table expectations stay authoritative
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while a byte store is in READ: store must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h000000EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort", "req_ready", 32'(req_ready), 32'd1);
    check("abort", "dm_we", 32'(dm_we), 32'd0);
    check("abort", "resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_we = 0; seen_rv = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (dm_we) seen_we++;
      if (resp_valid) seen_rv++;
    end
    check("abort", "late dm_we", 32'(seen_we), 32'd0);
    check("abort", "late resp_valid", 32'(seen_rv), 32'd0);
    check("abort", "dm word", dm_mem[4], ref_mem[4]);

    // Back-to-back loads with req_valid held high: one accept every third cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
    rv_count = 0;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("b2b c%0d", c), "req_ready", 32'(req_ready), 32'((c % 3) == 0));
      check($sformatf("b2b c%0d", c), "resp_valid", 32'(resp_valid), 32'((c % 3) == 2));
      if (resp_valid) begin
        rv_count++;
        check($sformatf("b2b c%0d", c), "resp_rdata", resp_rdata, ref_mem[4]);
      end
      if (c == 8) req_valid = 1'b0;
      @(negedge clk);
    end
    repeat (3) begin
      if (resp_valid) rv_count++;
      @(negedge clk);
    end
    check("b2b", "resp count", 32'(rv_count), 32'd3);

    // Random traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.sgn   = 1'($urandom_range(0, 1));
      v.wdata = $urandom;
      if ($urandom_range(0, 15) == 0) v.addr = {$urandom_range(3068, 3075), 2'b00};
      else v.addr = {$urandom_range(0, 15), 2'b00};
      v.addr = v.addr | 32'($urandom_range(0, 3));
      ref_access(v);
      apply($sformatf("rand%0d", n), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
